// File: rtl/rand_pkg.sv
// rand_pkg: shared FSM states and constants for the LFSR generator and its consumers.
package rand_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} rand_state_e;
    localparam int RAND_WORD_BITS = 64;
    localparam logic [63:0] RAND_INIT = 64'h5083_e3e3_8587_694b;
    function automatic int SLICES(input int word_bits, input int sample_bits);
        return word_bits / sample_bits;
    endfunction
endpackage

// File: rtl/rand_word_serializer.sv
// rand_word_serializer: pulls generator words and streams a burst of SAMPLE_BITS slices, LSB first.
module rand_word_serializer
    import rand_pkg::*;
#(
    parameter int WORD_BITS   = RAND_WORD_BITS,
    parameter int SAMPLE_BITS = 8,
    parameter int LEN_BITS    = 16
) (
    input  logic                   clk,
    input  logic                   rs_n,
    input  logic                   start,
    input  logic [LEN_BITS-1:0]    burst_len,
    input  logic [WORD_BITS-1:0]   rand_data,
    output logic                   rand_en,
    output logic [SAMPLE_BITS-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);
    localparam int NS = SLICES(WORD_BITS, SAMPLE_BITS);
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    if (WORD_BITS % SAMPLE_BITS != 0) begin : g_bad_width
        $error("SAMPLE_BITS must divide WORD_BITS");
    end

    rand_state_e           state_q, state_d;
    logic [LEN_BITS-1:0]   remaining_q, remaining_d;
    logic [SW-1:0]         slice_q, slice_d;
    logic [WORD_BITS-1:0]  word_q, word_d;

    always_ff @(posedge clk) begin
        if (!rs_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            slice_q     <= '0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            slice_q     <= slice_d;
            word_q      <= word_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        slice_d     = slice_q;
        word_d      = word_q;
        rand_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = burst_len;
                    state_d     = (burst_len != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                rand_en = 1'b1;
                word_d  = rand_data;
                slice_d = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (out_ready) begin
                    remaining_d = remaining_q - LEN_BITS'(1);
                    if (remaining_q == LEN_BITS'(1)) begin
                        state_d = DONE;
                    end else if (slice_q == SW'(NS - 1)) begin
                        // reload in the handshake cycle so the stream has no bubble
                        rand_en = 1'b1;
                        word_d  = rand_data;
                        slice_d = '0;
                    end else begin
                        word_d  = word_q >> SAMPLE_BITS;
                        slice_d = slice_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data  = word_q[SAMPLE_BITS-1:0];
    assign out_valid = (state_q == SHIFT);
    assign out_last  = out_valid && (remaining_q == LEN_BITS'(1));
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
endmodule

// File: tb/tb_rand_word_serializer.sv
// tb_rand_word_serializer: scoreboard bench with a behavioural LFSR generator beside the DUT.
module tb_rand_word_serializer;
    logic        clk = 0;
    logic        rs_n, start, out_ready, gen_rst;
    logic [15:0] burst_len;
    logic [63:0] lfsr;
    logic        rand_en, out_valid, out_last, busy, done;
    logic [7:0]  out_data;

    logic [8:0]  exp_q[$];
    int          n_cmp = 0, n_err = 0;
    int          en_cnt = 0, hs_cnt = 0, v_cnt = 0;

    always #5 clk = ~clk;

    rand_word_serializer dut (
        .clk(clk), .rs_n(rs_n), .start(start), .burst_len(burst_len),
        .rand_data(lfsr), .rand_en(rand_en), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    function automatic logic [63:0] lfsr_next(input logic [63:0] x);
        return {1'b0, x[63:1]} ^ (x[0] ? 64'hD800_0000_0000_0000 : 64'h0);
    endfunction

    always @(posedge clk)
        if (gen_rst) lfsr <= rand_pkg::RAND_INIT;
        else if (rand_en) lfsr <= lfsr_next(lfsr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every handshake
    always @(negedge clk) begin
        if (rs_n) begin
            if (rand_en) en_cnt++;
            if (out_valid) v_cnt++;
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_sample: got %0h expected none", {out_last, out_data});
                end else begin
                    chk("sample", {out_last, out_data}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic push_word(input logic [63:0] w, input int n, input bit last_at_end);
        for (int i = 0; i < n; i++)
            exp_q.push_back({last_at_end && (i == n - 1), w[8*i +: 8]});
    endtask

    task automatic gen_reset();
        gen_rst = 1;
        @(posedge clk); #1;
        gen_rst = 0;
    endtask

    task automatic do_start(input int len);
        start = 1;
        burst_len = 16'(len);
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (!done && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
    endtask

    int c, k;
    logic [63:0] w1;

    initial begin
        rs_n = 0; start = 0; burst_len = 0; out_ready = 0; gen_rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {rand_en, out_data, out_valid, out_last, busy, done}, 0);
        rs_n = 1; gen_rst = 0;

        // short burst
        en_cnt = 0; out_ready = 1;
        push_word(rand_pkg::RAND_INIT, 3, 1);
        do_start(3);
        chk("load_busy", {busy, rand_en, out_valid}, 3'b110);
        wait_done(c);
        chk("short_latency", c, 4);
        chk("short_rand_en", en_cnt, 1);
        @(posedge clk); #1;
        chk("short_done_pulse", {done, busy}, 0);
        chk("short_queue", exp_q.size(), 0);

        // word boundary
        gen_reset(); en_cnt = 0;
        push_word(rand_pkg::RAND_INIT, 8, 0);
        exp_q.push_back({1'b1, 8'ha5});
        do_start(9);
        wait_done(c);
        chk("boundary_latency", c, 10);
        chk("boundary_rand_en", en_cnt, 2);
        chk("boundary_queue", exp_q.size(), 0);

        // backpressure
        gen_reset(); en_cnt = 0; out_ready = 0;
        push_word(rand_pkg::RAND_INIT, 4, 1);
        do_start(4);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {out_valid, out_last, out_data}, {2'b10, 8'h4b});
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1;
        wait_done(c);
        chk("bp_rand_en", en_cnt, 1);
        chk("bp_queue", exp_q.size(), 0);

        // zero length
        @(posedge clk); #1;
        en_cnt = 0; v_cnt = 0;
        do_start(0);
        wait_done(c);
        chk("zero_latency", c, 0);
        @(posedge clk); #1;
        chk("zero_rand_en", en_cnt, 0);
        chk("zero_valid", v_cnt, 0);

        // reset mid-burst
        gen_reset(); en_cnt = 0; hs_cnt = 0;
        push_word(rand_pkg::RAND_INIT, 5, 0);
        do_start(20);
        k = 0;
        while (hs_cnt < 5 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("mid_handshakes", hs_cnt, 5);
        rs_n = 0;
        @(posedge clk); #1;
        chk("mid_reset_outputs", {rand_en, out_data, out_valid, out_last, busy, done}, 0);
        chk("mid_rand_en", en_cnt, 1);
        rs_n = 1;
        chk("mid_queue", exp_q.size(), 0);
        w1 = lfsr_next(rand_pkg::RAND_INIT);
        push_word(w1, 3, 1);
        en_cnt = 0;
        do_start(3);
        wait_done(c);
        chk("resume_rand_en", en_cnt, 1);
        chk("resume_queue", exp_q.size(), 0);

        // start while busy
        @(posedge clk); #1;
        gen_reset(); hs_cnt = 0;
        push_word(rand_pkg::RAND_INIT, 3, 1);
        do_start(3);
        @(posedge clk); #1;
        start = 1; burst_len = 7;
        @(posedge clk); #1;
        start = 0;
        wait_done(c);
        repeat (6) @(posedge clk);
        #1;
        chk("busy_start_count", hs_cnt, 3);
        chk("busy_start_idle", busy, 0);
        chk("busy_start_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rand_word_serializer.md
# rand_word_serializer

Downstream consumer of the 64-bit LFSR pseudo-random generator. On a start pulse it pulls random words from the generator and streams a programmed number of SAMPLE_BITS-wide samples out over a valid/ready interface. It drives the generator's `en`, so the generator advances exactly once per consumed word. It sits between the generator and the analyzer's stimulus/capture path, for example as a test-pattern source into a sample FIFO.

## Interface
- `WORD_BITS`, 64, width of the generator word; must equal the generator's `BITS`.
- `SAMPLE_BITS`, 8, output sample width; must divide `WORD_BITS` exactly.
- `LEN_BITS`, 16, width of the burst length (in samples).
- `clk`  in  1  single clock; the generator runs on the same posedge.
- `rs_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- `burst_len`  in  LEN_BITS  number of samples in the burst; sampled with `start`.
- `rand_data`  in  WORD_BITS  current generator output.
- `rand_en`  out  1  advance request to the generator (its `en`).
- `out_data`  out  SAMPLE_BITS  current sample.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the sample on a cycle where `out_valid && out_ready`.
- `out_last`  out  1  marks the final sample of a burst; qualified by `out_valid`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a burst ends.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- **IDLE**
  - `start` with `burst_len != 0`: latch `remaining = burst_len`, go to LOAD.
  - `start` with `burst_len == 0`: go to DONE directly. No `rand_en`, no `out_valid`.
- **LOAD** (one cycle)
  - `rand_en = 1`.
  - At the clock edge: `word <= rand_data`, `slice <= 0`, go to SHIFT.
- **SHIFT**
  - `out_data = word[SAMPLE_BITS-1:0]`, so the LSB slice goes first.
  - `out_valid = 1`; `out_last = (remaining == 1)`.
- **On a handshake in SHIFT**
  - `remaining` decrements by 1.
  - If `remaining == 1`: go to DONE.
  - Else if `slice == WORD_BITS/SAMPLE_BITS-1`:
    - `rand_en = 1` in the same cycle (combinational from the handshake);
    - `word <= rand_data`, `slice <= 0`;
    - this reload inserts no bubble.
  - Else: `word <= word >> SAMPLE_BITS`, `slice` increments by 1.
- **DONE**: `done = 1` for one cycle, then IDLE.
- `rand_en` is never asserted in IDLE or DONE. The generator therefore advances only for words that are actually started, and an unused tail of a word is discarded.
- `start` outside IDLE is ignored, with no queueing.
- **Reset** (`rs_n = 0` at an edge), including mid-burst:
  - next state is IDLE;
  - `remaining`, `slice` and `word` are cleared;
  - the generator is not reset by this block; it has its own reset.
- **Outputs after reset:** all outputs 0 (`rand_en`, `out_data`, `out_valid`, `out_last`, `busy`, `done`).

## Timing
- `start` accepted at edge N:
  - LOAD (with `rand_en`) during cycle N+1;
  - first `out_valid` in cycle N+2.
- With `out_ready` held high, samples are produced at 1 per cycle, including across word boundaries.
- With `out_ready` low, `out_data`, `out_last` and `out_valid` hold stable. `out_valid` never drops before the handshake.
- After the final handshake at edge M, `done` is high in cycle M+1 and `busy` is low in cycle M+2.
- A new `start` is accepted from cycle M+2.
- **Zero-length burst:** `start` at edge N gives `done` in cycle N+1.
- **`rand_en` count per burst of L>0 samples:** ceil(L·SAMPLE_BITS/WORD_BITS).

## Structure
- Shared package `rand_pkg`:
  - FSM state enum (IDLE, LOAD, SHIFT, DONE);
  - constants `RAND_WORD_BITS = 64`, `RAND_INIT = 64'h5083_e3e3_8587_694b`;
  - helper `SLICES = WORD_BITS/SAMPLE_BITS`.
- No sub-module. The generator is instantiated beside this block by the parent, not inside it.
- An elaboration-time check that `WORD_BITS % SAMPLE_BITS == 0`.

## Test plan
Bench instantiates the generator (reset to `RAND_INIT`) plus this block, with default parameters.
- **Short burst:** `burst_len = 3`, `out_ready = 1`
  - samples 0x4b, 0x69, 0x87;
  - `out_last` only on 0x87;
  - exactly one `rand_en` pulse; `done` one cycle later.
- **Word boundary:** `burst_len = 9`, `out_ready = 1`
  - first 8 samples 0x4b, 0x69, 0x87, 0x85, 0xe3, 0xe3, 0x83, 0x50;
  - 9th sample equals the LSB byte of the generator's next word;
  - 2 `rand_en` pulses; no gap between samples 8 and 9.
- **Backpressure:** `burst_len = 4`, `out_ready` low for 5 cycles after the first `out_valid`
  - `out_data` holds 0x4b throughout;
  - the sequence then resumes unchanged.
- **Zero length:** `burst_len = 0`
  - `done` in cycle N+1;
  - `out_valid` and `rand_en` never assert.
- **Reset mid-burst:** `burst_len = 20`; `rs_n = 0` for 1 cycle after 5 samples
  - all outputs 0 the next cycle, state IDLE;
  - a fresh `start` resumes from the generator's current word without error.
- **Start while busy:** second `start` pulsed during SHIFT
  - ignored;
  - sample count equals the first `burst_len` only.
